simon64_96_keygen: RTL and testbench

- Iterative SIMON64/96 key-expansion engine.
- Accepts one 96-bit key through a valid/ready handshake, then streams the 42 32-bit round keys k0..k41 one per handshake, in round order.
- Sits directly upstream of the round datapath (the iterative cipher core consumes one round key per round). It replaces the unrolled combinational key schedule with a 3-word sliding window and a z-sequence shift register.

---
 rtl/simon64_96_keygen.sv | 109 ++++++++++
 tb/tb_simon64_96_keygen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/simon64_96_keygen.sv
// ============================================================================
// simon64_96_keygen
// Iterative SIMON64/96 key expansion: accepts one 96-bit key, streams k0..k41.
// Revision: 1.0
// ============================================================================
`default_nettype none

module simon64_96_keygen #(
  parameter int          N_ROUNDS = 42,
  parameter logic [61:0] Z_SEQ    = 62'b10101111011100000011010010011000101000010001111110010110110011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [95:0] key,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [31:0] rk,
  output logic [5:0]  rk_index,
  output logic        rk_last,
  output logic        busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;
  localparam logic [5:0] LAST_IDX = 6'(N_ROUNDS - 1);

  logic [0:0]  state_q, state_d;
  logic [31:0] w0_q, w0_d;
  logic [31:0] w1_q, w1_d;
  logic [31:0] w2_q, w2_d;
  logic [5:0]  idx_q, idx_d;
  logic [61:0] z_q, z_d;

  logic [31:0] w_t0;
  logic [31:0] w_t1;
  logic [31:0] w_knew;

  // k(i+3) from k(i) and k(i+2); z_q[61] always holds z2[index]
  always_comb begin
    w_t0   = {w2_q[2:0], w2_q[31:3]};
    w_t1   = w_t0 ^ {w_t0[0], w_t0[31:1]};
    w_knew = w0_q ^ w_t1 ^ 32'hFFFF_FFFC ^ {31'b0, z_q[61]};
  end

  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    idx_d   = idx_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          w0_d    = key[31:0];
          w1_d    = key[63:32];
          w2_d    = key[95:64];
          idx_d   = 6'd0;
          z_d     = Z_SEQ;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            w0_d  = w1_q;
            w1_d  = w2_q;
            w2_d  = w_knew;
            idx_d = idx_q + 6'd1;
            z_d   = {z_q[60:0], z_q[61]};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      w0_q    <= 32'd0;
      w1_q    <= 32'd0;
      w2_q    <= 32'd0;
      idx_q   <= 6'd0;
      z_q     <= Z_SEQ;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      idx_q   <= idx_d;
      z_q     <= z_d;
    end
  end

  assign key_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rk_valid  = (state_q == S_EMIT);
  assign rk        = w0_q;
  assign rk_index  = idx_q;
  assign rk_last   = (state_q == S_EMIT) && (idx_q == LAST_IDX);

endmodule

`default_nettype wire

// File: tb/tb_simon64_96_keygen.sv
// ============================================================================
// tb_simon64_96_keygen
// Randomized self-checking bench against a software SIMON64/96 key schedule.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_simon64_96_keygen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [95:0] key;
  logic        rk_valid;
  logic        rk_ready;
  logic [31:0] rk;
  logic [5:0]  rk_index;
  logic        rk_last;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_k [0:41];
  logic [31:0] cap   [0:41];

  localparam logic [95:0] REF_KEY = 96'h13121110_0B0A0908_03020100;

  simon64_96_keygen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk        (rk),
    .rk_index  (rk_index),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return rotr(x, 32 - n);
  endfunction

  // Software key schedule straight from the SIMON definition
  task automatic gen_keys(input logic [95:0] k);
    logic [61:0] z;
    logic [31:0] t;
    z = 62'b10101111011100000011010010011000101000010001111110010110110011;
    exp_k[0] = k[31:0];
    exp_k[1] = k[63:32];
    exp_k[2] = k[95:64];
    for (int i = 3; i < 42; i++) begin
      t = rotr(exp_k[i-1], 3);
      t = t ^ rotr(t, 1);
      exp_k[i] = ~exp_k[i-3] ^ t ^ 32'd3 ^ {31'b0, z[61 - (i - 3)]};
    end
  endtask

  function automatic logic [63:0] encrypt(input logic [63:0] pt);
    logic [31:0] x, y, tmp;
    x = pt[63:32];
    y = pt[31:0];
    for (int i = 0; i < 42; i++) begin
      tmp = x;
      x = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ cap[i];
      y = tmp;
    end
    return {x, y};
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, "_rk_valid"}, 64'(rk_valid), 64'd0);
    check_val({tag, "_key_ready"}, 64'(key_ready), 64'd1);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_rk_last"}, 64'(rk_last), 64'd0);
  endtask

  task automatic present_key(input logic [95:0] k);
    @(negedge clk);
    check_val("load_key_ready", 64'(key_ready), 64'd1);
    key       = k;
    key_valid = 1'b1;
  endtask

  // mode 0: rk_ready held high; mode 1: random backpressure with long stalls at 2 and 41.
  // abort_at >= 0 pulses reset when that index is on the output.
  task automatic run_stream(input int mode, input bit hold_kv, input logic [95:0] next_key,
                            input int abort_at, output int got_n);
    int n = 0;
    int cyc = 0;
    int stall2 = 0;
    int stall41 = 0;
    bit rdy;
    while (n < 42 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (hold_kv) begin
        key       = next_key;
        key_valid = 1'b1;
      end else begin
        key_valid = 1'b0;
      end
      if (!rk_valid) begin
        check_val("stream_rk_valid", 64'(rk_valid), 64'd1);
        break;
      end
      check_val("rk", 64'(rk), 64'(exp_k[n]));
      check_val("rk_index", 64'(rk_index), 64'(n));
      check_val("rk_last", 64'(rk_last), 64'(n == 41));
      check_val("emit_key_ready", 64'(key_ready), 64'd0);
      check_val("emit_busy", 64'(busy), 64'd1);
      if (n == abort_at) begin
        rst_n    = 1'b0;
        rk_ready = 1'b1;
        got_n    = n;
        return;
      end
      if (mode == 0) rdy = 1'b1;
      else if (n == 2 && stall2 < 10) begin rdy = 1'b0; stall2++; end
      else if (n == 41 && stall41 < 10) begin rdy = 1'b0; stall41++; end
      else rdy = 1'($urandom_range(0, 1));
      rk_ready = rdy;
      if (rdy) begin
        cap[n] = rk;
        n++;
      end
    end
    if (n < 42 && cyc >= 2000) check_val("stream_timeout", 64'(n), 64'd42);
    got_n = n;
  endtask

  initial begin
    int got;
    logic [95:0] ka, kb;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key       = '0;
    rk_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check_val("reset_rk", 64'(rk), 64'd0);
    check_val("reset_rk_index", 64'(rk_index), 64'd0);
    rst_n = 1'b1;

    // Reference key, full-rate
    gen_keys(REF_KEY);
    present_key(REF_KEY);
    run_stream(0, 1'b0, '0, -1, got);
    check_val("ref_k3", 64'(cap[3]), 64'hFFAE9DCE);
    check_val("ref_cipher", encrypt(64'h6F722067_6E696C63), 64'h5CA2E27F_111A8FC8);
    @(negedge clk);
    check_idle("ref_end");

    // Reference key again under backpressure, plus random keys
    present_key(REF_KEY);
    run_stream(1, 1'b0, '0, -1, got);
    check_val("bp_cipher", encrypt(64'h6F722067_6E696C63), 64'h5CA2E27F_111A8FC8);
    for (int r = 0; r < 4; r++) begin
      ka = {$urandom, $urandom, $urandom};
      gen_keys(ka);
      @(negedge clk);
      check_idle("rand_gap");
      present_key(ka);
      run_stream(r % 2, 1'b0, '0, -1, got);
    end

    // key_valid held high: second key must wait until after rk_last
    @(negedge clk);
    ka = {$urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom};
    gen_keys(ka);
    present_key(ka);
    run_stream(1, 1'b1, kb, -1, got);
    @(negedge clk);
    check_idle("b2b_gap");
    gen_keys(kb);
    run_stream(0, 1'b0, '0, -1, got);

    // Reset mid-stream at index 20
    @(negedge clk);
    gen_keys(REF_KEY);
    present_key(REF_KEY);
    run_stream(0, 1'b0, '0, 20, got);
    check_val("abort_index", 64'(got), 64'd20);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("abort");
    check_val("abort_rk", 64'(rk), 64'd0);
    check_val("abort_rk_index", 64'(rk_index), 64'd0);
    present_key(REF_KEY);
    run_stream(1, 1'b0, '0, -1, got);

    // Reset held low with key_valid asserted
    @(negedge clk);
    rst_n     = 1'b0;
    key       = REF_KEY;
    key_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle("rst_hold");
      check_val("rst_hold_rk", 64'(rk), 64'd0);
    end
    key_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check_idle("rst_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
